// File: rtl/trig_sched4_if.sv
// trig_sched4_if: request inputs and strobe/status outputs of the trigger scheduler
interface trig_sched4_if #(parameter int HOLD_W = 8);
  logic [3:0] in;
  logic [3:0] enable;
  logic [HOLD_W-1:0] holdoff;
  logic clr_overrun;
  logic trigger;
  logic [1:0] trig_id;
  logic [3:0] pending;
  logic [3:0] overrun;
  modport master(output in, enable, holdoff, clr_overrun, input trigger, trig_id, pending, overrun);
  modport slave(input in, enable, holdoff, clr_overrun, output trigger, trig_id, pending, overrun);
endinterface

// File: rtl/trig_sched4.sv
// trig_sched4: four-channel edge-triggered request latch with round-robin strobe and holdoff
module trig_sched4 #(parameter int HOLD_W = 8) (
  input logic clk,
  input logic reset,
  trig_sched4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;
  state_t r_state, w_next;
  logic [3:0] r_stage1, r_stage2, r_pending, r_overrun;
  logic [3:0] w_edge, w_served, w_lost;
  logic [1:0] r_trig_id, r_last, w_pick;
  logic [HOLD_W-1:0] r_cnt;
  logic w_any;
  assign w_edge = r_stage1 & ~r_stage2 & bus.enable;
  assign w_any = |r_pending;
  assign w_served = (r_state == FIRE) ? (4'b0001 << r_trig_id) : 4'b0000;
  // a fresh edge on the channel being served re-arms it instead of counting as lost
  assign w_lost = w_edge & r_pending & ~w_served;
  // descending scan leaves the nearest pending channel after last_grant in w_pick
  always_comb begin
    w_pick = r_last;
    for (int k = 4; k >= 1; k--)
      if (r_pending[2'(r_last + 2'(k))]) w_pick = 2'(r_last + 2'(k));
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_any ? FIRE : IDLE;
      FIRE: w_next = (bus.holdoff != '0) ? HOLD : IDLE;
      HOLD: w_next = (r_cnt == HOLD_W'(1)) ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_trig_id <= '0;
      r_last <= 2'd3;
      r_cnt <= '0;
    end else begin
      r_stage1 <= bus.in;
      r_stage2 <= r_stage1;
      r_pending <= bus.enable & ((r_pending & ~w_served) | w_edge);
      r_overrun <= (r_overrun & ~{4{bus.clr_overrun}}) | w_lost;
      if (r_state == IDLE && w_any) begin
        r_trig_id <= w_pick;
        r_last <= w_pick;
      end
      r_cnt <= (r_state == FIRE) ? bus.holdoff : (r_state == HOLD) ? r_cnt - HOLD_W'(1) : r_cnt;
    end
  assign bus.trigger = (r_state == FIRE);
  assign bus.trig_id = r_trig_id;
  assign bus.pending = r_pending;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_trig_sched4.sv
// tb_trig_sched4: directed stimulus with a strobe scoreboard checked by an independent monitor
module tb_trig_sched4;
  logic clk = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int q_id[$];
  int q_cyc[$];
  int e_id, e_cyc, n;
  trig_sched4_if #(.HOLD_W(8)) bus();
  trig_sched4 #(.HOLD_W(8)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push(input int id, input int c);
    q_id.push_back(id);
    q_cyc.push_back(c);
  endtask
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_trigger"}, int'(bus.trigger), 0);
    chk({nm, "_trig_id"}, int'(bus.trig_id), 0);
    chk({nm, "_pending"}, int'(bus.pending), 0);
    chk({nm, "_overrun"}, int'(bus.overrun), 0);
  endtask
  always @(negedge clk)
    if (bus.trigger) begin
      if (q_id.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e_id = q_id.pop_front();
        e_cyc = q_cyc.pop_front();
        chk("strobe_id", int'(bus.trig_id), e_id);
        chk("strobe_cycle", cyc, e_cyc);
      end
    end
  initial begin
    bus.in = '0;
    bus.enable = 4'hF;
    bus.holdoff = '0;
    bus.clr_overrun = 0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 0;
    at(cyc + 3);
    // single request, no holdoff
    n = cyc;
    bus.in = 4'b0001;
    push(0, n + 3);
    at(n + 1); chk("t1_pend_e0", int'(bus.pending), 0);
    at(n + 2); chk("t1_pend_e1", int'(bus.pending), 1);
    at(n + 4); chk("t1_pend_done", int'(bus.pending), 0);
    bus.in = '0;
    at(n + 8);
    // all four together after reset: round-robin from channel 0, 7-cycle spacing
    reset = 1;
    at(cyc + 1); chk("t2_reset_pend", int'(bus.pending), 0);
    reset = 0;
    at(cyc + 2);
    bus.holdoff = 8'd5;
    n = cyc;
    bus.in = 4'b1111;
    push(0, n + 3); push(1, n + 10); push(2, n + 17); push(3, n + 24);
    at(n + 2); chk("t2_pend_all", int'(bus.pending), 15);
    at(n + 5); bus.holdoff = 8'd0;
    at(n + 8); bus.holdoff = 8'd5;
    at(n + 30); chk("t2_pend_done", int'(bus.pending), 0);
    bus.in = '0;
    at(n + 33);
    // lost request on channel 2 during holdoff, set beats clear, then clear
    bus.holdoff = 8'd10;
    n = cyc;
    bus.in = 4'b0100;
    push(2, n + 3);
    at(n + 5); bus.in = 4'b0000;
    at(n + 6); bus.in = 4'b0100;
    at(n + 8); chk("t3_pend_hold", int'(bus.pending), 4); bus.in = 4'b0000;
    at(n + 9); bus.in = 4'b0100;
    at(n + 10); bus.clr_overrun = 1;
    at(n + 11); bus.clr_overrun = 0;
    chk("t3_overrun_set_wins", int'(bus.overrun), 4);
    chk("t3_pend_once", int'(bus.pending), 4);
    push(2, n + 15);
    at(n + 17); chk("t3_pend_served", int'(bus.pending), 0);
    chk("t3_overrun_sticky", int'(bus.overrun), 4);
    at(n + 18); bus.clr_overrun = 1;
    at(n + 19); bus.clr_overrun = 0;
    chk("t3_overrun_clr", int'(bus.overrun), 0);
    bus.in = '0;
    at(n + 30);
    // channel 1 disabled while toggling alongside channel 0
    bus.holdoff = 8'd0;
    bus.enable = 4'b1101;
    n = cyc;
    for (int p = 0; p < 3; p++) begin
      at(n + 6 * p);
      bus.in = 4'b0011;
      push(0, n + 6 * p + 3);
      at(n + 6 * p + 2);
      chk("t4_pend_ch0_only", int'(bus.pending), 1);
      bus.in = '0;
    end
    at(n + 20);
    bus.enable = 4'hF;
    // reset during holdoff with channels 1 and 2 pending
    bus.holdoff = 8'd10;
    n = cyc;
    bus.in = 4'b1000;
    push(3, n + 3);
    at(n + 4); bus.in = 4'b1110;
    at(n + 7); chk("t5_pend_before", int'(bus.pending), 6);
    reset = 1;
    bus.in = '0;
    at(n + 8); chk_zero("t5_in_reset");
    reset = 0;
    at(n + 30); chk("t5_pend_after", int'(bus.pending), 0);
    // input already high across reset release yields one request
    n = cyc;
    reset = 1;
    bus.in = 4'b1000;
    at(n + 1); reset = 0;
    push(3, n + 4);
    at(n + 20); bus.in = '0;
    at(n + 24);
    // edge on the channel being strobed re-arms it without overrun
    bus.holdoff = 8'd0;
    n = cyc;
    bus.in = 4'b1000;
    push(3, n + 3);
    at(n + 1); bus.in = 4'b0000;
    at(n + 2); bus.in = 4'b1000;
    push(3, n + 5);
    at(n + 4); chk("t6_pend_rearm", int'(bus.pending), 8);
    at(n + 6);
    chk("t6_overrun", int'(bus.overrun), 0);
    chk("t6_pend_done", int'(bus.pending), 0);
    bus.in = '0;
    at(n + 12);
    chk("queue_drained", q_id.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
